// File: rtl/binar_pkg.sv
// Shared mode encodings for the adaptive luma binariser.
package binar_pkg;

    localparam logic [1:0] MODE_FIXED  = 2'd0;
    localparam logic [1:0] MODE_ADAPT  = 2'd1;
    localparam logic [1:0] MODE_WINDOW = 2'd2;
    localparam logic [1:0] MODE_INV    = 2'd3;

endpackage

// File: rtl/binar_mean_div.sv
// Restoring divider producing the frame-mean luma, one quotient bit per cycle.
// A start pulse while busy discards the running division and begins again.
module binar_mean_div #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 22
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DATA_W+CNT_W-1:0]   dividend,
    input  logic [CNT_W-1:0]          divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         quotient
);

    localparam int N  = DATA_W + CNT_W;
    localparam int SW = $clog2(N + 1);

    logic [CNT_W-1:0]  rem_r;
    logic [N-1:0]      q_r;
    logic [CNT_W-1:0]  dvs_r;
    logic [SW-1:0]     steps_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] quot_r;

    logic [CNT_W:0]    rem_sh_s;
    logic [CNT_W:0]    diff_s;
    logic [CNT_W-1:0]  rem_nxt_s;
    logic [N-1:0]      q_nxt_s;
    logic [DATA_W-1:0] quot_nxt_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits, clamp the result.
    always_comb begin
        rem_sh_s   = {rem_r, q_r[N-1]};
        diff_s     = rem_sh_s - {1'b0, dvs_r};
        rem_nxt_s  = rem_sh_s[CNT_W-1:0];
        q_nxt_s    = {q_r[N-2:0], 1'b0};
        quot_nxt_s = q_nxt_s[DATA_W-1:0];
        if (rem_sh_s >= {1'b0, dvs_r}) begin
            rem_nxt_s = diff_s[CNT_W-1:0];
            q_nxt_s   = {q_r[N-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[CNT_W-1:0];
            q_nxt_s   = {q_r[N-2:0], 1'b0};
        end
        if (|q_nxt_s[N-1:DATA_W]) begin
            quot_nxt_s = {DATA_W{1'b1}};
        end else begin
            quot_nxt_s = q_nxt_s[DATA_W-1:0];
        end
    end

    // Divider sequencing: load on start, iterate while busy, pulse done after the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_r   <= {CNT_W{1'b0}};
            q_r     <= {N{1'b0}};
            dvs_r   <= {CNT_W{1'b0}};
            steps_r <= {SW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quot_r  <= {DATA_W{1'b0}};
        end else if (start) begin
            rem_r   <= {CNT_W{1'b0}};
            q_r     <= dividend;
            dvs_r   <= divisor;
            steps_r <= SW'(N);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else if (busy_r) begin
            rem_r   <= rem_nxt_s;
            q_r     <= q_nxt_s;
            steps_r <= steps_r - SW'(1);
            if (steps_r == SW'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                quot_r <= quot_nxt_s;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quot_r;

endmodule

// File: rtl/binarization_adaptive.sv
// Luma-to-binary stage: fixed, frame-mean adaptive, window and inverted thresholding.
// The adaptive threshold is the mean luma of the previous frame.
module binarization_adaptive
    import binar_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 24,
    parameter int DEF_THRESH = 159,
    parameter int CNT_W      = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [DATA_W-1:0] y_in,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] thr_cfg,
    input  logic [DATA_W-1:0] thr_hi_cfg,
    output logic              vs_out,
    output logic              de_out,
    output logic [OUT_W-1:0]  data_bin,
    output logic [DATA_W-1:0] thr_cur,
    output logic              mean_valid
);

    localparam int                SUM_W = DATA_W + CNT_W;
    localparam logic [DATA_W-1:0] DEF_T = DATA_W'(DEF_THRESH);

    logic              vs_d_r, de_d_r;
    logic [1:0]        mode_sh_r;
    logic [DATA_W-1:0] lo_sh_r, hi_sh_r;
    logic [SUM_W-1:0]  sum_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] adapt_thr_r, adapt_act_r;
    logic              armed_r;
    logic [OUT_W-1:0]  data_bin_r;
    logic [DATA_W-1:0] thr_cur_r;
    logic              mean_valid_r;

    logic              vs_rise_s, de_rise_s, load_act_s, div_start_s;
    logic              div_busy_s, div_done_s;
    logic [DATA_W-1:0] div_q_s;
    logic [DATA_W-1:0] act_nxt_s, lo_nxt_s, thr_cur_nxt_s;
    logic [1:0]        mode_nxt_s;
    logic              pix_s;

    // Edge detection, frame-start divider kick and next-state view of the threshold config.
    always_comb begin
        vs_rise_s   = vs_in & ~vs_d_r;
        de_rise_s   = de_in & ~de_d_r;
        load_act_s  = de_rise_s & (armed_r | vs_rise_s);
        div_start_s = vs_rise_s & (cnt_r != {CNT_W{1'b0}});
        act_nxt_s   = adapt_act_r;
        mode_nxt_s  = mode_sh_r;
        lo_nxt_s    = lo_sh_r;
        if (load_act_s) begin
            act_nxt_s = adapt_thr_r;
        end else begin
            act_nxt_s = adapt_act_r;
        end
        if (vs_rise_s) begin
            mode_nxt_s = mode;
            lo_nxt_s   = thr_cfg;
        end else begin
            mode_nxt_s = mode_sh_r;
            lo_nxt_s   = lo_sh_r;
        end
        if (mode_nxt_s == MODE_ADAPT) begin
            thr_cur_nxt_s = act_nxt_s;
        end else begin
            thr_cur_nxt_s = lo_nxt_s;
        end
    end

    // Pixel decision against the shadowed config; blanking always yields 0.
    always_comb begin
        pix_s = 1'b0;
        if (!de_in) begin
            pix_s = 1'b0;
        end else begin
            case (mode_sh_r)
                MODE_FIXED:  pix_s = (y_in > lo_sh_r);
                MODE_ADAPT:  pix_s = (y_in > act_nxt_s);
                MODE_WINDOW: pix_s = (lo_sh_r < hi_sh_r) && (y_in > lo_sh_r) && (y_in <= hi_sh_r);
                MODE_INV:    pix_s = (y_in <= lo_sh_r);
                default:     pix_s = 1'b0;
            endcase
        end
    end

    // Sync delay line and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_d_r     <= 1'b0;
            de_d_r     <= 1'b0;
            data_bin_r <= {OUT_W{1'b0}};
            thr_cur_r  <= DEF_T;
        end else begin
            vs_d_r     <= vs_in;
            de_d_r     <= de_in;
            data_bin_r <= {OUT_W{pix_s}};
            thr_cur_r  <= thr_cur_nxt_s;
        end
    end

    // Config shadows update only at frame start so a frame is processed consistently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sh_r <= MODE_FIXED;
            lo_sh_r   <= DEF_T;
            hi_sh_r   <= {DATA_W{1'b0}};
        end else if (vs_rise_s) begin
            mode_sh_r <= mode;
            lo_sh_r   <= thr_cfg;
            hi_sh_r   <= thr_hi_cfg;
        end
    end

    // Per-frame luma sum and pixel count; restart at frame start, hold once the count saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r <= {SUM_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (vs_rise_s) begin
            sum_r <= de_in ? {{CNT_W{1'b0}}, y_in} : {SUM_W{1'b0}};
            cnt_r <= {{(CNT_W-1){1'b0}}, de_in};
        end else if (de_in && !(&cnt_r)) begin
            sum_r <= sum_r + {{CNT_W{1'b0}}, y_in};
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Capture a completed (not restarted) division as the new adaptive threshold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adapt_thr_r  <= DEF_T;
            mean_valid_r <= 1'b0;
        end else if (div_done_s && !div_busy_s) begin
            adapt_thr_r  <= div_q_s;
            mean_valid_r <= 1'b1;
        end
    end

    // Active threshold is frozen at the first line of each frame to avoid mid-frame tearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adapt_act_r <= DEF_T;
            armed_r     <= 1'b0;
        end else begin
            adapt_act_r <= act_nxt_s;
            if (load_act_s) begin
                armed_r <= 1'b0;
            end else if (vs_rise_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    binar_mean_div #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mean_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .dividend (sum_r),
        .divisor  (cnt_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_q_s)
    );

    assign vs_out     = vs_d_r;
    assign de_out     = de_d_r;
    assign data_bin   = data_bin_r;
    assign thr_cur    = thr_cur_r;
    assign mean_valid = mean_valid_r;

endmodule

// File: tb/tb_binarization_adaptive.sv
// Self-checking bench: frame-level reference model compared every cycle, plus directed literals.
module tb_binarization_adaptive;

    localparam int DATA_W  = 8;
    localparam int OUT_W   = 24;
    localparam int CNT_W   = 22;
    localparam int DEF_T   = 159;
    localparam int DIV_LAT = DATA_W + CNT_W + 1;  // start edge to adapt_thr write edge

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, vs_in, de_in;
    logic [DATA_W-1:0] y_in, thr_cfg, thr_hi_cfg;
    logic [1:0]        mode;
    logic              vs_out, de_out, mean_valid;
    logic [OUT_W-1:0]  data_bin;
    logic [DATA_W-1:0] thr_cur;

    int errors = 0;
    int checks = 0;

    binarization_adaptive dut (
        .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .de_in(de_in), .y_in(y_in),
        .mode(mode), .thr_cfg(thr_cfg), .thr_hi_cfg(thr_hi_cfg),
        .vs_out(vs_out), .de_out(de_out), .data_bin(data_bin),
        .thr_cur(thr_cur), .mean_valid(mean_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level view) ----------------
    int     e_cnt = 0;
    bit     m_vs_prev, m_de_prev, m_armed, m_mv, m_pend;
    int     m_mode, m_lo, m_hi, m_act, m_adapt, m_pend_mean, m_apply;
    longint m_sum, m_cnt;
    logic [31:0] x_vs, x_de, x_data, x_thr, x_mv;

    task automatic model_step();
        bit vr, dr, load, pix;
        int use_t, yv;
        longint mean;
        e_cnt++;
        if (!rst_n) begin
            m_vs_prev = 0; m_de_prev = 0; m_armed = 0; m_mv = 0; m_pend = 0;
            m_mode = 0; m_lo = DEF_T; m_hi = 0; m_act = DEF_T; m_adapt = DEF_T;
            m_sum = 0; m_cnt = 0;
            x_vs = 0; x_de = 0; x_data = 0; x_thr = DEF_T; x_mv = 0;
        end else begin
            yv    = int'(y_in);
            vr    = vs_in && !m_vs_prev;
            dr    = de_in && !m_de_prev;
            load  = dr && (m_armed || vr);
            use_t = load ? m_adapt : m_act;
            case (m_mode)
                0:       pix = yv > m_lo;
                1:       pix = yv > use_t;
                2:       pix = (yv > m_lo) && (yv <= m_hi);
                default: pix = yv <= m_lo;
            endcase
            if (!de_in) pix = 0;
            x_data = pix ? 32'h00FF_FFFF : 32'h0;
            x_vs   = {31'd0, vs_in};
            x_de   = {31'd0, de_in};
            if (m_pend && e_cnt == m_apply) begin
                m_adapt = m_pend_mean; m_mv = 1; m_pend = 0;
            end
            if (vr) begin
                m_mode = int'(mode); m_lo = int'(thr_cfg); m_hi = int'(thr_hi_cfg);
                if (m_cnt != 0) begin
                    mean = m_sum / m_cnt;
                    if (mean > 255) mean = 255;
                    m_pend = 1; m_pend_mean = int'(mean); m_apply = e_cnt + DIV_LAT;
                end
                m_sum = de_in ? yv : 0;
                m_cnt = de_in ? 1 : 0;
            end else if (de_in && m_cnt < (64'd1 << CNT_W) - 1) begin
                m_sum += yv; m_cnt++;
            end
            m_act   = use_t;
            m_armed = load ? 1'b0 : (vr ? 1'b1 : m_armed);
            m_vs_prev = vs_in; m_de_prev = de_in;
            x_thr = (m_mode == 1) ? m_act : m_lo;
            x_mv  = {31'd0, m_mv};
        end
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("vs_out", {31'd0, vs_out}, x_vs);
            check("de_out", {31'd0, de_out}, x_de);
            check("data_bin", {8'd0, data_bin}, x_data);
            check("thr_cur", {24'd0, thr_cur}, x_thr);
            check("mean_valid", {31'd0, mean_valid}, x_mv);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic d, input logic [7:0] y);
        @(negedge clk);
        vs_in = v; de_in = d; y_in = y;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'd0);
    endtask

    task automatic vs_pulse();
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0);
        idle(2);
    endtask

    task automatic pix_chk(input string nm, input logic [7:0] y, input logic [23:0] exp);
        drive(1'b0, 1'b1, y);
        @(posedge clk);
        #2;
        check(nm, {8'd0, data_bin}, {8'd0, exp});
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        check(nm, act, exp);
    endtask

    task automatic rdrive(input logic v, input logic d);
        @(negedge clk);
        rst_n = ($urandom_range(0, 499) != 0);
        vs_in = v; de_in = d;
        y_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom_range(0, 255));
        if ($urandom_range(0, 39) == 0) begin
            mode       = 2'($urandom_range(0, 3));
            thr_cfg    = 8'($urandom_range(0, 255));
            thr_hi_cfg = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0; vs_in = 1'b0; de_in = 1'b0; y_in = 8'd0;
        mode = 2'd0; thr_cfg = 8'd159; thr_hi_cfg = 8'd0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        lit("rst_thr_cur", {24'd0, thr_cur}, 32'd159);
        lit("rst_mean_valid", {31'd0, mean_valid}, 32'd0);
        lit("rst_data_bin", {8'd0, data_bin}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: fixed threshold
        idle(2); vs_pulse();
        pix_chk("t1_y159", 8'd159, 24'h000000);
        pix_chk("t1_y160", 8'd160, 24'hFFFFFF);
        pix_chk("t1_y0",   8'd0,   24'h000000);
        pix_chk("t1_y255", 8'd255, 24'hFFFFFF);
        idle(3);

        // 2: adaptive, frame A of four 100s
        mode = 2'd1; vs_pulse();
        repeat (4) drive(1'b0, 1'b1, 8'd100);
        idle(2); vs_pulse();
        w = 0;
        while (!mean_valid && w < 40) begin drive(1'b0, 1'b0, 8'd0); w++; end
        lit("t2_mean_valid", {31'd0, mean_valid}, 32'd1);
        idle(3);
        pix_chk("t2_y99",  8'd99,  24'h000000);
        lit("t2_thr_cur", {24'd0, thr_cur}, 32'd100);
        pix_chk("t2_y100", 8'd100, 24'h000000);
        pix_chk("t2_y101", 8'd101, 24'hFFFFFF);
        idle(3);

        // 3: window, then inverted bounds
        mode = 2'd2; thr_cfg = 8'd50; thr_hi_cfg = 8'd200; vs_pulse();
        pix_chk("t3_y50",  8'd50,  24'h000000);
        pix_chk("t3_y51",  8'd51,  24'hFFFFFF);
        pix_chk("t3_y200", 8'd200, 24'hFFFFFF);
        pix_chk("t3_y201", 8'd201, 24'h000000);
        idle(2);
        thr_cfg = 8'd200; thr_hi_cfg = 8'd50; vs_pulse();
        pix_chk("t3_inv_y100", 8'd100, 24'h000000);
        pix_chk("t3_inv_y200", 8'd200, 24'h000000);
        idle(2);

        // 4: inverted, mid-frame config change ignored
        mode = 2'd3; thr_cfg = 8'd128; vs_pulse();
        pix_chk("t4_y128", 8'd128, 24'hFFFFFF);
        pix_chk("t4_y129", 8'd129, 24'h000000);
        thr_cfg = 8'd0;
        pix_chk("t4_shadow_y128", 8'd128, 24'hFFFFFF);
        idle(2); vs_pulse();
        pix_chk("t4_new_y128", 8'd128, 24'h000000);
        pix_chk("t4_new_y0",   8'd0,   24'hFFFFFF);
        idle(40);

        // 5: empty frame keeps the mean (64), then abort/restart
        mode = 2'd1; vs_pulse(); idle(40);
        vs_pulse(); idle(40);
        pix_chk("t5_keep_y50", 8'd50, 24'h000000);
        lit("t5_keep_thr", {24'd0, thr_cur}, 32'd64);
        idle(2);
        repeat (4) drive(1'b0, 1'b1, 8'd20);
        vs_pulse();
        drive(1'b0, 1'b1, 8'd60); drive(1'b0, 1'b1, 8'd60);
        idle(4);
        vs_pulse();
        idle(20);
        pix_chk("t5_busy_y30", 8'd30, 24'h000000);
        lit("t5_busy_thr", {24'd0, thr_cur}, 32'd64);
        idle(10); vs_pulse();
        pix_chk("t5_y59", 8'd59, 24'h000000);
        lit("t5_thr60", {24'd0, thr_cur}, 32'd60);
        pix_chk("t5_y61", 8'd61, 24'hFFFFFF);
        idle(3);

        // 6: reset mid-divide and mid-line
        vs_pulse();
        repeat (3) drive(1'b0, 1'b1, 8'd77);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #2;
        lit("t6_data", {8'd0, data_bin}, 32'd0);
        lit("t6_de", {31'd0, de_out}, 32'd0);
        lit("t6_thr", {24'd0, thr_cur}, 32'd159);
        lit("t6_mv", {31'd0, mean_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1; de_in = 1'b0;
        idle(2); vs_pulse();
        pix_chk("t6_y159", 8'd159, 24'h000000);
        lit("t6_thr_adapt", {24'd0, thr_cur}, 32'd159);
        pix_chk("t6_y160", 8'd160, 24'hFFFFFF);
        idle(3);

        // Randomised frames against the model
        for (int f = 0; f < 60; f++) begin
            int vl, bl, gl;
            vl = $urandom_range(1, 3);
            bl = $urandom_range(5, 80);
            gl = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 45) : 0;
            repeat (vl) rdrive(1'b1, $urandom_range(0, 3) == 0);
            repeat (bl) rdrive(1'b0, $urandom_range(0, 9) < 7);
            repeat (gl) rdrive(1'b0, 1'b0);
        end
        @(negedge clk); rst_n = 1'b1;
        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
